// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-source round-robin word arbiter.
package mux4_arb_pkg;

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [1:0] SEL_A0 = 2'd0;
  localparam logic [1:0] SEL_A1 = 2'd1;
  localparam logic [1:0] SEL_A2 = 2'd2;
  localparam logic [1:0] SEL_A3 = 2'd3;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority pick: first set request scanning ptr, ptr+1, ... mod 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] idx
);

  assign any = |req;

  // Scan from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    idx = ptr;
    for (int o = 3; o >= 0; o--)
      if (req[ptr + 2'(o)]) idx = ptr + 2'(o);
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter + sequencer driving a 4:1 word mux into a registered
// valid/ready output stage, with per-grant burst limit.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [3:0]       last,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] A3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready
);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pick_any;
  logic [1:0]       pick_idx;
  logic             take;
  logic             acc;
  logic             rel;
  logic [WIDTH-1:0] cur;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    cur = A0;
    case (sel)
      SEL_A0: cur = A0;
      SEL_A1: cur = A1;
      SEL_A2: cur = A2;
      SEL_A3: cur = A3;
      default: cur = A0;
    endcase
  end

  assign take    = ~out_valid | out_ready;
  assign acc     = (state == GRANT) & req[sel] & take;
  assign cnt_nxt = cnt + 1'b1;
  // Owner gives up the channel on end of packet, burst limit, or withdrawal.
  assign rel     = (state == GRANT) &
                   (~req[sel] | (acc & (last[sel] | (cnt_nxt == CNT_W'(MAX_BURST)))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= '0;
      gnt       <= 4'b0;
      sel       <= SEL_A0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      // A new beat overwrites a draining one; otherwise a drain empties the stage.
      if (acc) begin
        out_data  <= cur;
        out_valid <= 1'b1;
        out_last  <= last[sel];
        cnt       <= cnt_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: if (pick_any) begin
          state <= GRANT;
          gnt   <= onehot4(pick_idx);
          sel   <= pick_idx;
          cnt   <= '0;
        end
        GRANT: if (rel) begin
          state <= IDLE;
          gnt   <= 4'b0;
          ptr   <= sel + 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench: per-source beat queues feed the arbiter; beat and grant
// scoreboards are checked by independent negedge monitors.
module tb_mux4_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, last;
  logic [31:0] a [4];
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [31:0] out_data;
  logic        out_valid, out_last, out_ready;

  int tests = 0;
  int fails = 0;

  logic [32:0] srcq [4][$];
  logic [32:0] expq [$];
  logic [1:0]  gq [$];
  logic [3:0]  en;
  logic [3:0]  prev_gnt = 4'b0;
  int          acccnt [4];

  mux4_rr_arbiter #(.WIDTH(32), .MAX_BURST(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last),
    .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]),
    .gnt(gnt), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bd(input int i, input int t, input int j);
    return 32'hDEAD_0000 + 32'(t << 12) + 32'(i << 8) + 32'(j);
  endfunction

  // mode: 0 = last on final beat, 1 = every beat last, 2 = never last
  task automatic src(input int i, input int t, input int n, input int mode);
    for (int j = 0; j < n; j++)
      srcq[i].push_back({(mode == 1) || (mode == 0 && j == n - 1), bd(i, t, j)});
  endtask

  task automatic exp_beat(input int i, input int t, input int j, input logic l);
    expq.push_back({l, bd(i, t, j)});
  endtask

  task automatic drive();
    logic [32:0] h;
    for (int i = 0; i < 4; i++) begin
      if (en[i] && srcq[i].size() > 0) begin
        h = srcq[i][0];
        req[i] = 1'b1; a[i] = h[31:0]; last[i] = h[32];
      end else begin
        req[i] = 1'b0; a[i] = 32'h0; last[i] = 1'b0;
      end
    end
  endtask

  // One clock: note which source beats the DUT will take, then advance them.
  task automatic cycle();
    logic [3:0] acc;
    @(negedge clk);
    acc = gnt & req & {4{~out_valid | out_ready}};
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (acc[i] && srcq[i].size() > 0) begin
        void'(srcq[i].pop_front());
        acccnt[i]++;
      end
    drive();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(srcq[0].size() == 0 && srcq[1].size() == 0 && srcq[2].size() == 0 &&
             srcq[3].size() == 0 && !out_valid && gnt == 4'b0 && expq.size() == 0) && n < 300) begin
      cycle();
      n++;
    end
    chk({name, "_timeout"}, 64'(n < 300), 64'd1);
    chk({name, "_exp_left"}, 64'(expq.size()), 64'd0);
    chk({name, "_gnt_left"}, 64'(gq.size()), 64'd0);
    cycle();
  endtask

  // Beat scoreboard: every consumed output beat must match the next expected one.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        tests++; fails++;
        $display("FAIL beat_extra actual=%0h expected=none @%0t", {out_last, out_data}, $time);
      end else begin
        chk("beat", 64'({out_last, out_data}), 64'(expq.pop_front()));
      end
    end
  end

  // Grant scoreboard: each new grant must match the expected order and follow a bubble.
  always @(negedge clk) begin
    if (rst_n && gnt != 4'b0 && gnt != prev_gnt) begin
      if (prev_gnt != 4'b0) chk("gnt_bubble", 64'(prev_gnt), 64'd0);
      if (gq.size() == 0) begin
        tests++; fails++;
        $display("FAIL gnt_extra actual=%0h expected=none @%0t", gnt, $time);
      end else begin
        logic [1:0] e;
        e = gq.pop_front();
        chk("gnt", 64'(gnt), 64'(4'b0001 << e));
        chk("sel", 64'(sel), 64'(e));
      end
    end
    prev_gnt = gnt;
  end

  initial begin
    int n;
    for (int i = 0; i < 4; i++) acccnt[i] = 0;
    rst_n = 1'b0; out_ready = 1'b1; en = 4'hF;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_last",  64'(out_last),  64'd0);
    chk("rst_gnt",   64'(gnt),       64'd0);
    chk("rst_sel",   64'(sel),       64'd0);
    rst_n = 1'b1;

    // Single source, 3-beat packet.
    src(0, 0, 3, 0);
    gq.push_back(2'd0);
    exp_beat(0, 0, 0, 1'b0); exp_beat(0, 0, 1, 1'b0); exp_beat(0, 0, 2, 1'b1);
    drive();
    wait_idle("t2");

    // Reset while a stalled beat sits in the output register.
    out_ready = 1'b0;
    src(2, 1, 4, 2);
    gq.push_back(2'd2);
    drive();
    n = 0;
    while (!out_valid && n < 20) begin cycle(); n++; end
    chk("t1_valid_before", 64'(out_valid), 64'd1);
    cycle(); cycle();
    rst_n = 1'b0;
    #1;
    chk("t1_rst_valid", 64'(out_valid), 64'd0);
    chk("t1_rst_data",  64'(out_data),  64'd0);
    chk("t1_rst_last",  64'(out_last),  64'd0);
    chk("t1_rst_gnt",   64'(gnt),       64'd0);
    chk("t1_rst_sel",   64'(sel),       64'd0);
    srcq[2].delete();
    drive();
    cycle();
    rst_n = 1'b1; out_ready = 1'b1;
    cycle(); cycle();
    chk("t1_idle_gnt",   64'(gnt),       64'd0);
    chk("t1_idle_valid", 64'(out_valid), 64'd0);

    // All four requesting, single-beat packets: strict rotation from ptr=0.
    for (int i = 0; i < 4; i++) src(i, 3, 2, 1);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) begin
        gq.push_back(2'(i));
        exp_beat(i, 3, r, 1'b1);
      end
    drive();
    wait_idle("t3");

    // Forced rotation at MAX_BURST: src0 4 beats, src1 packet, src0 resumes.
    src(0, 4, 10, 2);
    src(1, 4, 2, 0);
    gq.push_back(2'd0); gq.push_back(2'd1); gq.push_back(2'd0); gq.push_back(2'd0);
    for (int j = 0; j < 4; j++) exp_beat(0, 4, j, 1'b0);
    exp_beat(1, 4, 0, 1'b0); exp_beat(1, 4, 1, 1'b1);
    for (int j = 4; j < 10; j++) exp_beat(0, 4, j, 1'b0);
    drive();
    wait_idle("t4");

    // Backpressure: first beat held for 5 cycles, then the whole packet drains.
    out_ready = 1'b0;
    src(1, 5, 6, 0);
    gq.push_back(2'd1); gq.push_back(2'd1);
    for (int j = 0; j < 6; j++) exp_beat(1, 5, j, j == 5);
    drive();
    n = 0;
    while (!out_valid && n < 20) begin cycle(); n++; end
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t5_hold_data",  64'(out_data),  64'(bd(1, 5, 0)));
      chk("t5_hold_valid", 64'(out_valid), 64'd1);
      chk("t5_hold_gnt",   64'(gnt),       64'h2);
      chk("t5_hold_sel",   64'(sel),       64'd1);
    end
    out_ready = 1'b1;
    wait_idle("t5");

    // Withdraw mid-packet, then ptr=0 gives src0 priority over returning src3.
    for (int i = 0; i < 4; i++) acccnt[i] = 0;
    src(3, 6, 4, 0);
    gq.push_back(2'd3);
    exp_beat(3, 6, 0, 1'b0); exp_beat(3, 6, 1, 1'b0);
    drive();
    n = 0;
    while (acccnt[3] < 2 && n < 50) begin cycle(); n++; end
    chk("t6_beats_before", 64'(acccnt[3]), 64'd2);
    en[3] = 1'b0;
    drive();
    cycle();
    chk("t6_gnt_drop", 64'(gnt), 64'd0);
    n = 0;
    while ((expq.size() != 0 || out_valid) && n < 20) begin cycle(); n++; end
    chk("t6_drained", 64'(expq.size()), 64'd0);
    src(0, 6, 1, 0);
    en[3] = 1'b1;
    gq.push_back(2'd0); gq.push_back(2'd3);
    exp_beat(0, 6, 0, 1'b1); exp_beat(3, 6, 2, 1'b0); exp_beat(3, 6, 3, 1'b1);
    drive();
    wait_idle("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
